glb_port_cfg_seq: RTL
=====================

GLB_PORT_CFG_SEQ -- requirements
Module: glb_port_cfg_seq

Interface
REQ-001 SHALL have parameter NUM_PORT, default 4, number of GLB ports sequenced.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, width of the per-port address maximum.
REQ-003 SHALL have parameter NUM_BANK, default 8, width of the per-port bank flag.
REQ-004 SHALL have parameter TO_WIDTH, default 16, width of the timeout counter (used only when the macro in REQ-030 is defined).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-007 SHALL have port net_start, input, 1, request to run one network configuration.
REQ-008 SHALL have port cfg_dat, input, CW = 1+NUM_PORT+ADDR_WIDTH+NUM_BANK, layer word packed as {last, port_mask, addr_max, bank_flg} with MSB first.
REQ-009 SHALL have ports cfg_vld (input, 1) and cfg_rdy (output, 1), the layer-word handshake from a first-word-fall-through FIFO.
REQ-010 SHALL have ports glb_cfg_vld (output, 1) and glb_cfg_rdy (input, 1), the per-port configuration handshake.
REQ-011 SHALL have ports glb_cfg_port (output, clog2(NUM_PORT)), glb_cfg_addrmax (output, ADDR_WIDTH) and glb_cfg_bankflg (output, NUM_BANK), the configuration payload.
REQ-012 SHALL have port sya_start, output, 1, one-cycle datapath start pulse.
REQ-013 SHALL have port glb_port_fnh, input, NUM_PORT, per-port finish level or pulse.
REQ-014 SHALL have port glb_port_rst, output, NUM_PORT, one-cycle per-port reset pulse.
REQ-015 SHALL have ports busy (output, 1, high whenever the state is not IDLE) and net_done (output, 1, one-cycle pulse).

Function
REQ-016 SHALL implement the states IDLE, FETCH, CFG, START, WORK, PRST and DONE.
REQ-017 SHALL move IDLE->FETCH when net_start=1; net_start SHALL be ignored in every other state.
REQ-018 SHALL assert cfg_rdy only in FETCH; on cfg_vld&cfg_rdy it SHALL latch the word into a layer register.
- Non-zero port_mask: next state CFG.
- Zero port_mask: no-op layer; next state DONE if last=1, else stay in FETCH.
REQ-019 SHALL, in CFG, present the lowest-index port not yet configured in the masked set, with glb_cfg_vld=1 and addr_max/bank_flg taken from the layer register.
- The payload SHALL hold stable until glb_cfg_rdy=1.
- After the handshake, the next masked port SHALL be presented on the following cycle; there is no bubble requirement beyond that one-per-cycle rate.
REQ-020 SHALL go CFG->START after the handshake of the highest masked port.
- START SHALL pulse sya_start for exactly one cycle, then move to WORK.
REQ-021 SHALL OR glb_port_fnh&port_mask into a sticky done register every cycle in START and WORK.
- WORK SHALL exit to PRST in the first cycle that (sticky | (glb_port_fnh&port_mask)) == port_mask.
- Finish arriving during START SHALL be counted.
REQ-022 SHALL drive glb_port_rst=port_mask for exactly one cycle in PRST and clear the sticky register.
- Next state: DONE if last=1, else FETCH.
REQ-023 SHALL pulse net_done for one cycle in DONE, then return to IDLE.
REQ-024 SHALL ignore glb_port_fnh bits outside port_mask and in all states other than START and WORK.
REQ-025 SHALL register every output, except that cfg_rdy and glb_cfg_vld MAY be decoded from state.
- Latency from net_start to the first cfg_rdy SHALL be 1 cycle.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set state=IDLE and clear the layer register, the sticky register and the port index.
REQ-027 SHALL hold cfg_rdy, glb_cfg_vld, sya_start, glb_port_rst, net_done and busy at 0, and glb_cfg_port, glb_cfg_addrmax and glb_cfg_bankflg at 0, during and after reset.
REQ-028 SHALL, when reset is applied mid-operation in any state, abort immediately with no glb_port_rst or net_done pulse; an in-flight CFG handshake is dropped.
REQ-029 SHALL have timeout_err (REQ-031) reset to 0.

Configuration
REQ-030 SHALL, with GLB_PORT_CFG_SEQ_TIMEOUT_EN defined, add input cfg_timeout (TO_WIDTH) and output timeout_err (1), plus a cycle counter cleared on entry to WORK.
REQ-031 SHALL, with the macro defined, set timeout_err sticky when the counter reaches cfg_timeout while in WORK, and force WORK->PRST.
- timeout_err SHALL clear only on reset or on net_start accepted in IDLE.
- cfg_timeout=0 SHALL disable the timeout.
REQ-032 SHALL, without the macro, omit those ports and the counter; WORK waits indefinitely.

Verification
REQ-033 SHALL cover a single layer: {last=1, mask=4'b0101, addr_max=12'h3FF, bank=8'h0F} with glb_cfg_rdy held 1 -> cfg ports 0 then 2 on consecutive cycles, one sya_start, then fnh[0] followed by fnh[2] -> glb_port_rst=4'b0101 for one cycle, then net_done.
REQ-034 SHALL cover ready stalls: glb_cfg_rdy low for 3 cycles on port 2 -> payload stable throughout, no skipped port.
REQ-035 SHALL cover a two-layer network: mask 4'b1111 then mask 4'b0000 with last=1 -> second layer produces no sya_start, then net_done.
REQ-036 SHALL cover fnh handling: fnh=4'b1111 in the START cycle with mask 4'b0011 -> exit to PRST on the first WORK cycle; fnh[3] ignored.
REQ-037 SHALL cover reset mid-run: rst in WORK -> all outputs 0 next cycle, IDLE, no net_done.
REQ-038 SHALL cover the timeout with the macro defined: cfg_timeout=16'd10 and no fnh -> timeout_err=1 at the 10th WORK cycle, then PRST.

Source files
------------

// File: rtl/glb_port_cfg_seq.sv
// glb_port_cfg_seq
// Sequences one network configuration across the GLB ports. The sequencer
// fetches layer words from a first-word-fall-through FIFO and hands each masked
// port its address/bank configuration, one port per cycle. It then pulses the
// datapath start and waits until every masked port has finished. Finally it
// pulses the per-port resets and either fetches the next layer or reports
// network done.
//
// Optional feature: define GLB_PORT_CFG_SEQ_TIMEOUT_EN to add a WORK-phase
// timeout. This adds the cfg_timeout input, the timeout_err output and a WORK
// cycle counter. A cfg_timeout of 0 disables the timeout.

module glb_port_cfg_seq #(
    parameter  int NUM_PORT   = 4,
    parameter  int ADDR_WIDTH = 12,
    parameter  int NUM_BANK   = 8,
    parameter  int TO_WIDTH   = 16,
    localparam int CW         = 1 + NUM_PORT + ADDR_WIDTH + NUM_BANK,
    localparam int PW         = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  net_start,
    input  logic [CW-1:0]         cfg_dat,
    input  logic                  cfg_vld,
    output logic                  cfg_rdy,
    output logic                  glb_cfg_vld,
    input  logic                  glb_cfg_rdy,
    output logic [PW-1:0]         glb_cfg_port,
    output logic [ADDR_WIDTH-1:0] glb_cfg_addrmax,
    output logic [NUM_BANK-1:0]   glb_cfg_bankflg,
    output logic                  sya_start,
    input  logic [NUM_PORT-1:0]   glb_port_fnh,
    output logic [NUM_PORT-1:0]   glb_port_rst,
`ifdef GLB_PORT_CFG_SEQ_TIMEOUT_EN
    input  logic [TO_WIDTH-1:0]   cfg_timeout,
    output logic                  timeout_err,
`endif
    output logic                  busy,
    output logic                  net_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CFG,
        START,
        WORK,
        PRST,
        DONE
    } state_t;

    state_t state;

    // Layer register: the currently active layer word
    logic                  lyr_last;
    logic [NUM_PORT-1:0]   lyr_mask;
    logic [ADDR_WIDTH-1:0] lyr_addr;
    logic [NUM_BANK-1:0]   lyr_bank;

    // Ports of the current layer still waiting for their configuration
    logic [NUM_PORT-1:0]   pend;
    // Ports of the current layer that have already reported finish
    logic [NUM_PORT-1:0]   sticky;

    // Fields of the incoming layer word
    logic                  in_last;
    logic [NUM_PORT-1:0]   in_mask;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [NUM_BANK-1:0]   in_bank;

    assign in_last = cfg_dat[CW-1];
    assign in_mask = cfg_dat[CW-2 -: NUM_PORT];
    assign in_addr = cfg_dat[NUM_BANK +: ADDR_WIDTH];
    assign in_bank = cfg_dat[NUM_BANK-1:0];

    // The handshake-ready signals are pure state decodes
    assign cfg_rdy     = (state == FETCH);
    assign glb_cfg_vld = (state == CFG);

    // Returns the lowest set index of v (0 if v is empty)
    function automatic logic [PW-1:0] low_idx(input logic [NUM_PORT-1:0] v);
        logic found;
        low_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_PORT; i++) begin
            if (!found && v[i]) begin
                low_idx = PW'(i);
                found   = 1'b1;
            end
        end
    endfunction

    logic [NUM_PORT-1:0] port_bit;
    logic [NUM_PORT-1:0] pend_rem;
    logic [NUM_PORT-1:0] fnh_m;
    logic                fin_all;
    logic                to_hit;

    // Derive the remaining-port set and the all-finished condition
    always_comb begin
        port_bit = NUM_PORT'(1) << glb_cfg_port;
        pend_rem = pend & ~port_bit;
        fnh_m    = glb_port_fnh & lyr_mask;
        fin_all  = ((sticky | fnh_m) == lyr_mask);
    end

`ifdef GLB_PORT_CFG_SEQ_TIMEOUT_EN
    logic [TO_WIDTH-1:0] to_cnt;
    logic [TO_WIDTH-1:0] to_cnt_inc;

    // The timeout fires in the WORK cycle whose ordinal equals cfg_timeout
    always_comb begin
        to_cnt_inc = to_cnt + TO_WIDTH'(1);
        to_hit     = (cfg_timeout != '0) && (to_cnt_inc == cfg_timeout);
    end
`else
    assign to_hit = 1'b0;
`endif

    // Sequencer FSM with registered pulse and payload outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            lyr_last        <= 1'b0;
            lyr_mask        <= '0;
            lyr_addr        <= '0;
            lyr_bank        <= '0;
            pend            <= '0;
            sticky          <= '0;
            glb_cfg_port    <= '0;
            glb_cfg_addrmax <= '0;
            glb_cfg_bankflg <= '0;
            sya_start       <= 1'b0;
            glb_port_rst    <= '0;
            busy            <= 1'b0;
            net_done        <= 1'b0;
`ifdef GLB_PORT_CFG_SEQ_TIMEOUT_EN
            to_cnt          <= '0;
            timeout_err     <= 1'b0;
`endif
        end else begin
            sya_start    <= 1'b0;
            glb_port_rst <= '0;
            net_done     <= 1'b0;

            case (state)
                IDLE: begin
                    if (net_start) begin
                        state <= FETCH;
                        busy  <= 1'b1;
`ifdef GLB_PORT_CFG_SEQ_TIMEOUT_EN
                        timeout_err <= 1'b0;
`endif
                    end
                end

                FETCH: begin
                    if (cfg_vld) begin
                        lyr_last <= in_last;
                        lyr_mask <= in_mask;
                        lyr_addr <= in_addr;
                        lyr_bank <= in_bank;
                        if (in_mask != '0) begin
                            state           <= CFG;
                            pend            <= in_mask;
                            glb_cfg_port    <= low_idx(in_mask);
                            glb_cfg_addrmax <= in_addr;
                            glb_cfg_bankflg <= in_bank;
                        end else if (in_last) begin
                            state    <= DONE;
                            net_done <= 1'b1;
                        end
                    end
                end

                CFG: begin
                    if (glb_cfg_rdy) begin
                        pend <= pend_rem;
                        if (pend_rem != '0) begin
                            glb_cfg_port <= low_idx(pend_rem);
                        end else begin
                            state           <= START;
                            sya_start       <= 1'b1;
                            glb_cfg_port    <= '0;
                            glb_cfg_addrmax <= '0;
                            glb_cfg_bankflg <= '0;
                        end
                    end
                end

                START: begin
                    sticky <= sticky | fnh_m;
                    state  <= WORK;
`ifdef GLB_PORT_CFG_SEQ_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end

                WORK: begin
                    sticky <= sticky | fnh_m;
`ifdef GLB_PORT_CFG_SEQ_TIMEOUT_EN
                    to_cnt <= to_cnt_inc;
`endif
                    if (fin_all) begin
                        state        <= PRST;
                        glb_port_rst <= lyr_mask;
                    end else if (to_hit) begin
                        state        <= PRST;
                        glb_port_rst <= lyr_mask;
`ifdef GLB_PORT_CFG_SEQ_TIMEOUT_EN
                        timeout_err  <= 1'b1;
`endif
                    end
                end

                PRST: begin
                    sticky <= '0;
                    if (lyr_last) begin
                        state    <= DONE;
                        net_done <= 1'b1;
                    end else begin
                        state <= FETCH;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
